// File: rtl/player_request_arbiter.sv
// ---------------------------------------------------------------------------
// player_request_arbiter
//
// Round-robin arbiter sharing the single game-logic input channel among four
// players. Single-cycle button pulses are latched as pending requests, and
// one request at a time is offered to the game engine over a valid/ack
// handshake. The search for the next grant starts just after the last
// acknowledged player, so no player can starve the others.
//
// Optional feature (compile-time macro):
//   ARB_COOLDOWN_EN - per-player lockout of COOLDOWN_CYCLES clocks after that
//                     player's grant is acknowledged; presses during the
//                     lockout (including the ack cycle itself) are dropped.
//                     Without the macro no counters exist and presses are
//                     always accepted (a press in the ack cycle survives).
//
// Parameters:
//   N_PLAYERS        number of requesters (fixed at 4, grant_id is 2 bits)
//   COOLDOWN_CYCLES  lockout length in clk cycles (ARB_COOLDOWN_EN only)
//   CD_W             cooldown counter width, 2**CD_W > COOLDOWN_CYCLES
//                    (ARB_COOLDOWN_EN only)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-low reset
//   btn_pulse    in   [3:0] one-cycle press pulses, bit i = player i
//   grant_ack    in   engine consumed the offer (meaningful while grant_valid)
//   grant_valid  out  a request is being offered
//   grant_id     out  [1:0] player being offered, stable while grant_valid
//   pending      out  [3:0] latched, not-yet-granted requests
//   busy         out  grant_valid OR any pending bit
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module player_request_arbiter #(
  parameter int unsigned N_PLAYERS = 4
`ifdef ARB_COOLDOWN_EN
  ,
  parameter int unsigned COOLDOWN_CYCLES = 1000,
  parameter int unsigned CD_W            = 10
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] btn_pulse,
  input  logic                 grant_ack,
  output logic                 grant_valid,
  output logic [1:0]           grant_id,
  output logic [N_PLAYERS-1:0] pending,
  output logic                 busy
);

  localparam int unsigned ID_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_OFFER = 2'b01
  } state_t;

  state_t                r_state;
  logic [N_PLAYERS-1:0]  r_pending;
  logic [ID_W-1:0]       r_last_id;
  logic [ID_W-1:0]       r_grant_id;
  logic                  r_grant_valid;
  logic                  r_busy;

  logic                  w_ack_fire;
  logic [N_PLAYERS-1:0]  w_clr;
  logic [N_PLAYERS-1:0]  w_accept;
  logic [N_PLAYERS-1:0]  w_pending_nxt;
  logic                  w_valid_nxt;
  logic [ID_W-1:0]       w_pick;

  // First requester found searching upward from last+1, wrapping modulo 4.
  // Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_PLAYERS-1:0] req,
                                               input logic [ID_W-1:0]      last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    pick = last;
    for (int k = N_PLAYERS; k >= 1; k--) begin
      cand = last + ID_W'(k);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign w_pick     = rr_pick(r_pending, r_last_id);
  assign w_ack_fire = (r_state == S_OFFER) && grant_ack;

  // One-hot clear of the acknowledged player's pending bit.
  always_comb begin
    w_clr = '0;
    if (w_ack_fire) w_clr[r_grant_id] = 1'b1;
  end

`ifdef ARB_COOLDOWN_EN
  logic [CD_W-1:0] r_cd [N_PLAYERS];

  // A press is accepted only while the player's lockout counter reads zero
  // and the player is not being acknowledged this very cycle.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      w_accept[i] = (r_cd[i] == '0) && !w_clr[i];
    end
  end

  // Lockout counters: load on the ack edge, then count down to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_PLAYERS; i++) r_cd[i] <= '0;
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (w_clr[i]) begin
          r_cd[i] <= CD_W'(COOLDOWN_CYCLES);
        end else if (r_cd[i] != '0) begin
          r_cd[i] <= r_cd[i] - CD_W'(1);
        end
      end
    end
  end
`else
  assign w_accept = '1;
`endif

  // Set wins over clear, so a press landing in the ack cycle is kept.
  assign w_pending_nxt = (r_pending & ~w_clr) | (btn_pulse & w_accept);

  // Value grant_valid takes after this edge; also feeds the registered busy.
  always_comb begin
    w_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE:  w_valid_nxt = |r_pending;
      S_OFFER: w_valid_nxt = !grant_ack;
      default: w_valid_nxt = 1'b0;
    endcase
  end

  // Offer state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pending     <= '0;
      r_last_id     <= ID_W'(N_PLAYERS - 1);
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_grant_valid <= w_valid_nxt;
      r_busy        <= w_valid_nxt | (|w_pending_nxt);
      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_grant_id <= w_pick;
            r_state    <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (grant_ack) begin
            r_last_id <= r_grant_id;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign pending     = r_pending;
  assign busy        = r_busy;

endmodule

// File: doc/player_request_arbiter.md
# player_request_arbiter

Round-robin arbiter that shares the single game-logic input channel among four players. Each player's shaped single-cycle button pulse is latched as a pending request. One request at a time is offered to the game engine over a valid/ack handshake. Sits between the per-player button shapers and the game state machine, so that simultaneous presses are never lost and no player can starve the others.

## Interface
- `N_PLAYERS`, 4, number of requesters; fixed at 4 in this revision, so `grant_id` is 2 bits.
- `COOLDOWN_CYCLES`, 1000, lockout length in clk cycles after a player's grant is acknowledged; used only with `ARB_COOLDOWN_EN`.
- `CD_W`, 10, cooldown counter width; must satisfy 2^CD_W > COOLDOWN_CYCLES.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `btn_pulse`  in  4  one-cycle press pulses, bit i = player i.
- `grant_ack`  in  1  game engine consumed the offered request; meaningful only while `grant_valid`=1.
- `grant_valid`  out  1  a request is being offered.
- `grant_id`  out  2  player being offered; stable while `grant_valid`=1.
- `pending`  out  4  latched, not-yet-granted requests.
- `busy`  out  1  `grant_valid` OR any bit of `pending`.

## Operation
- **Pending latch:** `pending[i]` is set by `btn_pulse[i]`. It is cleared when player i's offer is acknowledged. If a set and a clear for the same bit land in the same cycle, set wins: a new press during the ack cycle is kept. Repeated pulses while already pending coalesce into one request.
- **State machine, IDLE:** `grant_valid`=0. If `pending`≠0, pick the first set bit searching from `last_id`+1 upward, wrapping modulo 4. Register it into `grant_id`, then go to OFFER. Otherwise stay in IDLE.
- **State machine, OFFER:** `grant_valid`=1 and `grant_id` is held. On `grant_ack`=1, clear `pending[grant_id]`, set `last_id` to `grant_id`, and return to IDLE. Without ack, stay in OFFER indefinitely; there is no timeout.
- **Ack outside OFFER:** `grant_ack` while in IDLE is ignored.
- **Fairness:** every pending player is offered within 4 grants.
- **Invalid state encodings:** go to IDLE.
- **Reset (rst=0):** state=IDLE, `pending`=0, `last_id`=3 (so player 0 has first priority), `grant_id`=0, `grant_valid`=0, `busy`=0, all cooldown counters=0. A reset mid-OFFER drops the offer and all pending requests.

## Timing
- A pulse at edge t makes `pending` visible after t. If the FSM is in IDLE, `grant_valid`=1 after edge t+1. Press-to-offer latency is 2 cycles.
- With ack sampled at edge a, `grant_valid`=0 after a, and `pending`/`busy` update after a.
- The earliest next offer is after edge a+1, i.e. a mandatory 1-cycle gap with `grant_valid` low.
- Sustained throughput is one grant per 2 cycles when the engine acks immediately.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- **`ARB_COOLDOWN_EN` defined:**
  - Each player has a down-counter, loaded with COOLDOWN_CYCLES on the edge where that player's ack is sampled.
  - While the counter is nonzero, `btn_pulse[i]` is discarded and does not set pending. The counter decrements by 1 per cycle and saturates at 0.
  - A pulse in the ack cycle itself is also discarded.
  - Pulses are accepted again from the cycle in which the counter reads 0.
- **`ARB_COOLDOWN_EN` not defined:** no counters are built, and pulses are always accepted, including the set-wins rule in the ack cycle.

## Test plan
- **Single press:** reset, then pulse `btn_pulse`=0100. Expect `pending`=0100 next cycle and `grant_valid`=1 with `grant_id`=2 one cycle later. Ack → `grant_valid`=0 and `pending`=0 next cycle.
- **Simultaneous presses:** pulse 1111 after reset, then ack each offer immediately. Expect grant order 0,1,2,3, with `grant_valid` low for exactly 1 cycle between offers.
- **Round-robin wrap:** grant player 2, then set `pending`=0101. Expect the next grants to be 0 then 2, not 2 first.
- **Held offer:** offer player 1 with ack withheld for 20 cycles while pulses arrive for players 0 and 3. `grant_id` stays 1; after ack, `pending`=1001, and the next offer is player 3.
- **Set-wins:** pulse player 1 in the same cycle its ack is sampled. Without the macro, `pending[1]`=1 afterwards and a re-offer follows. With `ARB_COOLDOWN_EN` and COOLDOWN_CYCLES=8, the pulse is dropped, a pulse 5 cycles later is dropped, and a pulse 9 cycles later is accepted.
- **Reset mid-OFFER:** assert rst=0 during OFFER with `pending`=1010. The next cycle shows all outputs 0, and the first grant after release goes to the lowest pending player.
